// File: rtl/icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_fill_ctrl
//   Instruction-cache miss handler. While idle it forwards the fetch address
//   to the L1 for lookup. On a miss it latches the line base and fetches the
//   line word by word from backing memory, writing each word into the L1.
//   Words go in ascending offset order, so the last write (the highest
//   offset) is the one that validates the line.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   cpu_req, cpu_addr     fetch request and its word address
//   cache_hit             L1 hit flag for the address on cache_addr
//   stall                 holds the fetch stage during a miss or fill
//   cache_we, cache_addr,
//   cache_data            L1 lookup address and fill write port
//   mem_rd, mem_addr      backing-memory read request
//   mem_valid, mem_rdata  backing-memory read response
//   miss_count            line fills started, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module icache_fill_ctrl #(
    parameter int ADDR_SIZE      = 14,
    parameter int WORD_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_req,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic                 cache_hit,
    output logic                 stall,
    output logic                 cache_we,
    output logic [ADDR_SIZE-1:0] cache_addr,
    output logic [WORD_SIZE-1:0] cache_data,
    output logic                 mem_rd,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic                 mem_valid,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [15:0]          miss_count
);

    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam logic [OFF_BITS-1:0]  LAST_OFF = OFF_BITS'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_SIZE-1:0] OFF_MASK = ADDR_SIZE'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_e;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] base_q,  base_d;
    logic [OFF_BITS-1:0]  cnt_q,   cnt_d;
    logic [WORD_SIZE-1:0] data_q,  data_d;
    logic [15:0]          miss_q,  miss_d;

    logic                 miss;
    logic [ADDR_SIZE-1:0] line_addr;

    assign miss      = cpu_req & ~cache_hit;
    // base has its offset bits cleared, so OR-ing in the counter is an add.
    assign line_addr = base_q | {{(ADDR_SIZE-OFF_BITS){1'b0}}, cnt_q};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            miss_q  <= miss_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        miss_d  = miss_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    base_d  = cpu_addr & ~OFF_MASK;
                    cnt_d   = '0;
                    miss_d  = (miss_q == '1) ? miss_q : miss_q + 16'd1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_valid) begin
                    data_d  = mem_rdata;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (cnt_q == LAST_OFF) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall      = 1'b1;
        cache_we   = 1'b0;
        mem_rd     = 1'b0;
        cache_addr = line_addr;
        case (state_q)
            IDLE: begin
                stall      = miss;
                cache_addr = cpu_addr;
            end
            FETCH:   mem_rd     = 1'b1;
            WRITE:   cache_we   = 1'b1;
            DONE:    cache_addr = cpu_addr;
            default: ;
        endcase
    end

    assign mem_addr   = line_addr;
    assign cache_data = data_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_fill_ctrl
//   Directed bench for icache_fill_ctrl. A small memory model answers reads
//   after a programmable latency with data derived from the address
//   (32'hC0DE_0000 | addr); scenario tasks check lookups, fills, mid-fill
//   reset and miss counter saturation.
// ---------------------------------------------------------------------------
module tb_icache_fill_ctrl;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int WPL = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cache_hit;
    logic          stall;
    logic          cache_we;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_data;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [15:0]   miss_count;

    int vectors = 0;
    int errors  = 0;

    // memory model controls
    int lat      = 1;
    bit spurious = 1'b0;
    int wait_cnt = 0;

    icache_fill_ctrl #(
        .ADDR_SIZE      (AW),
        .WORD_SIZE      (DW),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cache_hit  (cache_hit),
        .stall      (stall),
        .cache_we   (cache_we),
        .cache_addr (cache_addr),
        .cache_data (cache_data),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Memory: valid in the lat-th cycle of a read; optionally drives a
    // spurious valid while no read is pending.
    always @(negedge clk) begin
        if (mem_rd === 1'b1) begin
            if (wait_cnt == lat - 1) begin
                mem_valid = 1'b1;
                mem_rdata = 32'hC0DE_0000 | 32'(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_valid = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_valid = spurious;
            mem_rdata = 32'hDEAD_BEEF;
            wait_cnt  = 0;
        end
    end

    // Trigger a miss at addr and follow the whole fill, then check it.
    task automatic run_fill(input logic [AW-1:0] addr, input int l,
                            input bit move_addr, input logic [15:0] exp_miss);
        logic [AW-1:0] base;
        int cycles, we_n, rd_cycles, acc_n, bad_addr, bad_data, bad_mem, overlap;
        base = addr & ~AW'(WPL - 1);
        cycles = 0; we_n = 0; rd_cycles = 0; acc_n = 0;
        bad_addr = 0; bad_data = 0; bad_mem = 0; overlap = 0;
        @(negedge clk);
        lat = l;
        cpu_addr = addr; cpu_req = 1'b1; cache_hit = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL miss_stall: got %b, expected 1", stall);
        end
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        while (stall === 1'b1 && cycles < 400) begin
            cycles++;
            if (cache_we === 1'b1) begin
                if (cache_addr !== base + AW'(we_n)) bad_addr++;
                if (cache_data !== (32'hC0DE_0000 | 32'(base + AW'(we_n)))) bad_data++;
                if (mem_rd !== 1'b0) overlap++;
                we_n++;
            end
            if (mem_rd === 1'b1) begin
                rd_cycles++;
                if (mem_valid === 1'b1) begin
                    if (mem_addr !== base + AW'(acc_n)) bad_mem++;
                    acc_n++;
                end
            end
            if (move_addr && cycles == 5) cpu_addr = 14'h3FFF;
            @(negedge clk);
            #1;
        end
        vectors++;
        if (cycles !== WPL * (l + 1) + 1) begin
            errors++; $display("FAIL fill_cycles: got %0d, expected %0d", cycles, WPL * (l + 1) + 1);
        end
        vectors++;
        if (we_n !== WPL) begin
            errors++; $display("FAIL we_pulses: got %0d, expected %0d", we_n, WPL);
        end
        vectors++;
        if (bad_addr !== 0 || bad_data !== 0 || overlap !== 0) begin
            errors++; $display("FAIL fill_writes: bad_addr %0d bad_data %0d overlap %0d, expected all 0", bad_addr, bad_data, overlap);
        end
        vectors++;
        if (acc_n !== WPL || bad_mem !== 0) begin
            errors++; $display("FAIL mem_reads: got %0d reads with %0d bad addrs, expected %0d with 0", acc_n, bad_mem, WPL);
        end
        vectors++;
        if (rd_cycles !== WPL * l) begin
            errors++; $display("FAIL mem_rd_cycles: got %0d, expected %0d", rd_cycles, WPL * l);
        end
        vectors++;
        if (miss_count !== exp_miss) begin
            errors++; $display("FAIL miss_count: got %h, expected %h", miss_count, exp_miss);
        end
        vectors++;
        if (cache_we !== 1'b0 || mem_rd !== 1'b0 || cache_addr !== cpu_addr) begin
            errors++; $display("FAIL idle_after_fill: we %b rd %b cache_addr %h, expected 0 0 %h", cache_we, mem_rd, cache_addr, cpu_addr);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cache_hit = 1'b0;
        #1;
        vectors++;
        if ({stall, cache_we, mem_rd} !== 3'b000 || cache_data !== '0 || miss_count !== 16'h0) begin
            errors++; $display("FAIL reset_state: stall/we/rd %b data %h miss %h, expected 000 0 0", {stall, cache_we, mem_rd}, cache_data, miss_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_hit();
        int act;
        act = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 14'h0040; cache_hit = 1'b1;
        #1;
        vectors++;
        if ({stall, mem_rd, cache_we} !== 3'b000 || cache_addr !== 14'h0040) begin
            errors++; $display("FAIL hit_lookup: stall/rd/we %b addr %h, expected 000 0040", {stall, mem_rd, cache_we}, cache_addr);
        end
        repeat (4) begin
            @(negedge clk); #1;
            if (mem_rd !== 1'b0 || cache_we !== 1'b0 || stall !== 1'b0) act++;
        end
        vectors++;
        if (act !== 0 || miss_count !== 16'h0) begin
            errors++; $display("FAIL hit_hold: activity %0d miss %h, expected 0 0000", act, miss_count);
        end
        cpu_req = 1'b0; cache_hit = 1'b0;
    endtask

    task automatic test_miss_zero_wait();
        run_fill(14'h0123, 1, 1'b0, 16'd1);
    endtask

    task automatic test_miss_latency();
        spurious = 1'b1;
        run_fill(14'h0123, 3, 1'b0, 16'd2);
        spurious = 1'b0;
    endtask

    task automatic test_addr_change();
        run_fill(14'h0123, 2, 1'b1, 16'd3);
    endtask

    task automatic test_reset_mid_fill();
        int n, guard, act;
        n = 0; guard = 0; act = 0;
        @(negedge clk);
        lat = 1;
        cpu_addr = 14'h0123; cpu_req = 1'b1; cache_hit = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        while (n < 4 && guard < 100) begin
            #1;
            if (cache_we === 1'b1) n++;
            guard++;
            if (n < 4) @(negedge clk);
        end
        vectors++;
        if (n !== 4) begin
            errors++; $display("FAIL reach_4th_write: got %0d writes, expected 4", n);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({stall, cache_we, mem_rd} !== 3'b000 || cache_data !== '0 ||
            miss_count !== 16'h0 || mem_addr !== '0) begin
            errors++; $display("FAIL async_reset: stall/we/rd %b data %h miss %h mem_addr %h, expected 000 0 0 0",
                               {stall, cache_we, mem_rd}, cache_data, miss_count, mem_addr);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            if (cache_we !== 1'b0 || mem_rd !== 1'b0) act++;
        end
        vectors++;
        if (act !== 0) begin
            errors++; $display("FAIL post_reset_quiet: got %0d active cycles, expected 0", act);
        end
        // line was never completed, so the lookup still misses
        run_fill(14'h0123, 1, 1'b0, 16'd1);
    endtask

    task automatic test_miss_saturation();
        @(negedge clk);
        force dut.miss_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.miss_q;
        run_fill(14'h0200, 1, 1'b0, 16'hFFFF);
        run_fill(14'h0345, 1, 1'b0, 16'hFFFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hit();
        test_miss_zero_wait();
        test_miss_latency();
        test_addr_change();
        test_reset_mid_fill();
        test_miss_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/icache_fill_ctrl.md
ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 14, word-address width of the L1 and of memory.
REQ-002 Parameter WORD_SIZE, default 32, data word width.
REQ-003 Parameter WORDS_PER_LINE, default 8, power of two ≥2, words per cache line; OFF_BITS = log2(WORDS_PER_LINE).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 cpu_req  input  1  fetch stage requests the instruction at cpu_addr.
REQ-008 cpu_addr  input  ADDR_SIZE  word address of the requested instruction.
REQ-009 cache_hit  input  1  L1 hit flag for the address currently on cache_addr.
REQ-010 stall  output  1  holds the fetch stage while a line is missing or being filled.
REQ-011 cache_we  output  1  L1 write strobe, one word per pulse.
REQ-012 cache_addr  output  ADDR_SIZE  address to the L1 (lookup or fill).
REQ-013 cache_data  output  WORD_SIZE  fill data to the L1.
REQ-014 mem_rd  output  1  read request to backing memory.
REQ-015 mem_addr  output  ADDR_SIZE  word address of the memory read.
REQ-016 mem_valid  input  1  memory returns mem_rdata for the pending mem_rd.
REQ-017 mem_rdata  input  WORD_SIZE  memory read data.
REQ-018 miss_count  output  16  number of line fills started, saturating.

Function
REQ-019 States: IDLE, FETCH, WRITE, DONE; exactly one active.
REQ-020 IDLE: cache_addr = cpu_addr; stall = cpu_req & ~cache_hit (combinational); mem_rd = 0; cache_we = 0.
REQ-021 IDLE, cpu_req=1 and cache_hit=0 at a rising edge: latch base = cpu_addr with low OFF_BITS cleared, word counter cnt = 0, increment miss_count unless already 0xFFFF, go FETCH.
REQ-022 cpu_addr changes after the latch have no effect on the fill in progress.
REQ-023 FETCH: mem_rd = 1, mem_addr = base | cnt, stall = 1; mem_rd held high until mem_valid sampled 1.
REQ-024 FETCH with mem_valid=1: register mem_rdata into cache_data, go WRITE; memory latency unbounded, zero-wait (valid in first FETCH cycle) supported.
REQ-025 WRITE: cache_we = 1 for exactly one cycle, cache_addr = base | cnt, cache_data stable, mem_rd = 0, stall = 1.
REQ-026 WRITE with cnt < WORDS_PER_LINE-1: cnt increments, go FETCH.
REQ-027 WRITE with cnt = WORDS_PER_LINE-1: go DONE; words always written in ascending offset order so the last write (offset WORDS_PER_LINE-1) validates the line in the L1.
REQ-028 DONE: one cycle, cache_addr = cpu_addr, stall = 1, mem_rd = 0, cache_we = 0; unconditionally go IDLE where lookup is re-evaluated.
REQ-029 mem_valid outside FETCH is ignored.
REQ-030 cache_we never asserted outside WRITE; mem_rd never asserted outside FETCH.
REQ-031 Fill of one line with memory latency L cycles (valid in L-th FETCH cycle) takes WORDS_PER_LINE*(L+1)+1 cycles from leaving IDLE to returning to IDLE.
REQ-032 cnt is OFF_BITS wide; it does not wrap within a fill.
REQ-033 miss_count saturates at 0xFFFF and holds.

Reset
REQ-034 reset_n=0 immediately forces IDLE, cnt=0, base=0, cache_data=0, miss_count=0, cache_we=0, mem_rd=0, regardless of clock.
REQ-035 Reset mid-fill abandons the fill; the partial line is never marked valid since the last word was not written; no further cache_we or mem_rd until a new miss.
REQ-036 First rising edge after reset_n deasserts evaluates IDLE normally.

Verification
REQ-037 Hit: cpu_req=1, cpu_addr=0x0040, cache_hit=1 -> stall=0, mem_rd=0, cache_we=0, miss_count stays 0.
REQ-038 Miss, zero-wait memory: cpu_addr=0x0123, cache_hit=0 -> mem_addr sequence 0x0120..0x0127, 8 cache_we pulses with cache_addr 0x0120..0x0127 and matching data, return to IDLE after 17 cycles, miss_count=1.
REQ-039 Miss, latency 3: same address -> mem_rd held 3 cycles per word, 33-cycle fill, stall=1 throughout, cache_we pulses exactly 8.
REQ-040 cpu_addr changed to 0x3FFF mid-fill -> mem_addr/cache_addr continue from latched base 0x0120.
REQ-041 reset_n pulsed low after 4th cache_we -> outputs zero asynchronously, no further writes, miss_count=0; subsequent lookup at 0x0123 still misses.
REQ-042 miss_count preloaded by 65535 misses -> next miss leaves it at 0xFFFF.
